scr1_dmem_bram_port: RTL and testbench

Downstream slave for one SCR1 data-memory router port (port1/port2 region). Converts the SCR1 dmem req/ack/resp protocol into accesses to a synchronous single-port FPGA block RAM with configurable read latency. Handles byte-lane alignment of write and read data, per-byte write enables, and error responses for illegal requests. Supports back-to-back requests, with a new request accepted in the same cycle as the previous response.

---
 rtl/scr1_dmem_bram_port.sv | 138 +++++++++++++
 tb/tb_scr1_dmem_bram_port.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmem_bram_port.sv
// SCR1 dmem router port slave: turns req/ack/resp transactions into accesses
// to a synchronous single-port block RAM with 1- or 2-cycle read latency.

package scr1_memif_pkg;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'd0,
        SCR1_MEM_CMD_WR    = 2'd1,
        SCR1_MEM_CMD_ERROR = 2'd2
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'd0,
        SCR1_MEM_WIDTH_HWORD = 2'd1,
        SCR1_MEM_WIDTH_WORD  = 2'd2,
        SCR1_MEM_WIDTH_ERROR = 2'd3
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;

endpackage

module scr1_dmem_bram_port
    import scr1_memif_pkg::*;
#(
    parameter int RAM_AWIDTH   = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dmem_req,
    output logic                  dmem_req_ack,
    input  type_scr1_mem_cmd_e    dmem_cmd,
    input  type_scr1_mem_width_e  dmem_width,
    input  logic [31:0]           dmem_addr,
    input  logic [31:0]           dmem_wdata,
    output logic [31:0]           dmem_rdata,
    output type_scr1_mem_resp_e   dmem_resp,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [RAM_AWIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_e;

    localparam logic [1:0] LAT_CNT = 2'(READ_LATENCY);

    state_e     state;
    logic [1:0] cnt;
    logic [1:0] off;
    logic       is_rd;
    logic       is_err;

    logic       resp_cycle;
    logic       accept;
    logic       req_err;
    logic       legal_rd;
    logic [3:0] be_mask;
    logic       unused_addr_hi;

    assign resp_cycle   = (state == ST_PEND) && (cnt == 2'd1);
    assign dmem_req_ack = (state == ST_IDLE) || resp_cycle;
    assign accept       = dmem_req && dmem_req_ack;

    // Upper address bits simply alias onto the RAM.
    assign unused_addr_hi = ^dmem_addr[31:RAM_AWIDTH+2];

    always_comb begin
        req_err = 1'b0;
        be_mask = 4'b1111;
        if ((dmem_cmd != SCR1_MEM_CMD_RD) && (dmem_cmd != SCR1_MEM_CMD_WR)) begin
            req_err = 1'b1;
        end
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
                be_mask = 4'b0001 << dmem_addr[1:0];
            end
            SCR1_MEM_WIDTH_HWORD: begin
                be_mask = 4'b0011 << dmem_addr[1:0];
                if (dmem_addr[0]) req_err = 1'b1;
            end
            SCR1_MEM_WIDTH_WORD: begin
                be_mask = 4'b1111;
                if (dmem_addr[1:0] != 2'b00) req_err = 1'b1;
            end
            default: begin
                req_err = 1'b1;
            end
        endcase
    end

    assign legal_rd  = !req_err && (dmem_cmd == SCR1_MEM_CMD_RD);
    assign ram_en    = accept && !req_err;
    assign ram_we    = (ram_en && (dmem_cmd == SCR1_MEM_CMD_WR)) ? be_mask : 4'b0000;
    assign ram_addr  = dmem_addr[RAM_AWIDTH+1:2];
    assign ram_wdata = dmem_wdata << {dmem_addr[1:0], 3'b000};

    always_comb begin
        dmem_resp = SCR1_MEM_RESP_NOTRDY;
        if (resp_cycle) begin
            dmem_resp = is_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        end
    end

    // Read data stays right-aligned but unmasked; the core extends/masks it.
    assign dmem_rdata = (resp_cycle && is_rd && !is_err) ? (ram_rdata >> {off, 3'b000}) : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= 2'd0;
            off    <= 2'd0;
            is_rd  <= 1'b0;
            is_err <= 1'b0;
        end else if (accept) begin
            state  <= ST_PEND;
            cnt    <= legal_rd ? LAT_CNT : 2'd1;
            off    <= dmem_addr[1:0];
            is_rd  <= legal_rd;
            is_err <= req_err;
        end else if (resp_cycle) begin
            state  <= ST_IDLE;
            cnt    <= 2'd0;
        end else if (state == ST_PEND) begin
            cnt    <= cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_scr1_dmem_bram_port.sv
// Scoreboard bench for scr1_dmem_bram_port: one instance at READ_LATENCY=1
// and one at READ_LATENCY=2, each backed by a behavioural block RAM.

module tb_scr1_dmem_bram_port;
    import scr1_memif_pkg::*;

    localparam int AW = 14;

    typedef struct {
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
        int                  due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 dmem_req     [2];
    logic                 dmem_req_ack [2];
    type_scr1_mem_cmd_e   dmem_cmd     [2];
    type_scr1_mem_width_e dmem_width   [2];
    logic [31:0]          dmem_addr    [2];
    logic [31:0]          dmem_wdata   [2];
    logic [31:0]          dmem_rdata   [2];
    type_scr1_mem_resp_e  dmem_resp    [2];
    logic                 ram_en       [2];
    logic [3:0]           ram_we       [2];
    logic [AW-1:0]        ram_addr     [2];
    logic [31:0]          ram_wdata    [2];
    logic [31:0]          ram_rdata    [2];

    logic [31:0] ram_mem [2][2**AW];
    logic [31:0] ref_mem [2][2**AW];
    logic [31:0] l2_stage;
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          w;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    scr1_dmem_bram_port #(.RAM_AWIDTH(AW), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .dmem_req(dmem_req[0]), .dmem_req_ack(dmem_req_ack[0]),
        .dmem_cmd(dmem_cmd[0]), .dmem_width(dmem_width[0]),
        .dmem_addr(dmem_addr[0]), .dmem_wdata(dmem_wdata[0]),
        .dmem_rdata(dmem_rdata[0]), .dmem_resp(dmem_resp[0]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    scr1_dmem_bram_port #(.RAM_AWIDTH(AW), .READ_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .dmem_req(dmem_req[1]), .dmem_req_ack(dmem_req_ack[1]),
        .dmem_cmd(dmem_cmd[1]), .dmem_width(dmem_width[1]),
        .dmem_addr(dmem_addr[1]), .dmem_wdata(dmem_wdata[1]),
        .dmem_rdata(dmem_rdata[1]), .dmem_resp(dmem_resp[1]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    // Read-first block RAMs; the second one carries an extra output register.
    always @(posedge clk) begin
        if (ram_en[0]) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[0][b]) ram_mem[0][ram_addr[0]][8*b +: 8] <= ram_wdata[0][8*b +: 8];
            ram_rdata[0] <= ram_mem[0][ram_addr[0]];
        end
        if (ram_en[1]) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[1][b]) ram_mem[1][ram_addr[1]][8*b +: 8] <= ram_wdata[1][8*b +: 8];
            l2_stage <= ram_mem[1][ram_addr[1]];
        end
        ram_rdata[1] <= l2_stage;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every response must match the oldest outstanding expectation, on its due cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (dmem_resp[d] != SCR1_MEM_RESP_NOTRDY) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        checkOutput("stale_resp", 32'(dmem_resp[d]), 32'(SCR1_MEM_RESP_NOTRDY));
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        checkOutput("resp",       32'(dmem_resp[d]), 32'(e.resp));
                        checkOutput("rdata",      dmem_rdata[d],     e.rdata);
                        checkOutput("resp_cycle", 32'(cyc),          32'(e.due));
                    end
                end else begin
                    checkOutput("idle_rdata", dmem_rdata[d], 32'd0);
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input type_scr1_mem_cmd_e cmd,
                                 input type_scr1_mem_width_e width,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int waits);
        exp_t        e;
        logic        legal;
        logic [3:0]  mask;
        logic [31:0] shifted;
        int          widx;
        dmem_req[d]   = 1'b1;
        dmem_cmd[d]   = cmd;
        dmem_width[d] = width;
        dmem_addr[d]  = addr;
        dmem_wdata[d] = wdata;
        waits = 0;
        @(negedge clk);
        while (!dmem_req_ack[d] && waits < 20) begin
            checkOutput("wait_notrdy", 32'(dmem_resp[d]), 32'(SCR1_MEM_RESP_NOTRDY));
            waits++;
            @(negedge clk);
        end
        if (!dmem_req_ack[d]) begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
            dmem_req[d] = 1'b0;
            return;
        end
        legal = (cmd == SCR1_MEM_CMD_RD) || (cmd == SCR1_MEM_CMD_WR);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  mask = 4'b0001 << addr[1:0];
            SCR1_MEM_WIDTH_HWORD: begin mask = 4'b0011 << addr[1:0]; legal = legal && !addr[0]; end
            SCR1_MEM_WIDTH_WORD:  begin mask = 4'b1111; legal = legal && (addr[1:0] == 2'b00); end
            default:              begin mask = 4'b0000; legal = 1'b0; end
        endcase
        shifted = wdata << (8 * int'(addr[1:0]));
        widx    = int'(addr[AW+1:2]);
        checkOutput("ram_en", 32'(ram_en[d]), 32'(legal));
        if (legal) begin
            checkOutput("ram_addr", 32'(ram_addr[d]), 32'(addr[AW+1:2]));
            checkOutput("ram_we", 32'(ram_we[d]), (cmd == SCR1_MEM_CMD_WR) ? 32'(mask) : 32'd0);
            if (cmd == SCR1_MEM_CMD_WR) checkOutput("ram_wdata", ram_wdata[d], shifted);
        end
        e.due = cyc + ((legal && cmd == SCR1_MEM_CMD_RD) ? d + 1 : 1);
        if (!legal) begin
            e.resp  = SCR1_MEM_RESP_RDY_ER;
            e.rdata = 32'd0;
        end else if (cmd == SCR1_MEM_CMD_WR) begin
            for (int b = 0; b < 4; b++)
                if (mask[b]) ref_mem[d][widx][8*b +: 8] = shifted[8*b +: 8];
            e.resp  = SCR1_MEM_RESP_RDY_OK;
            e.rdata = 32'd0;
        end else begin
            e.resp  = SCR1_MEM_RESP_RDY_OK;
            e.rdata = ref_mem[d][widx] >> (8 * int'(addr[1:0]));
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic dropRequest(input int d);
        dmem_req[d] = 1'b0;
    endtask

    task automatic drainQueues();
        int guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #1;
        checkOutput("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            dmem_req[d]   = 1'b0;
            dmem_cmd[d]   = SCR1_MEM_CMD_RD;
            dmem_width[d] = SCR1_MEM_WIDTH_WORD;
            dmem_addr[d]  = 32'd0;
            dmem_wdata[d] = 32'd0;
            for (int i = 0; i < 2**AW; i++) ref_mem[d][i] = 32'd0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_resp",  32'(dmem_resp[d]), 32'(SCR1_MEM_RESP_NOTRDY));
            checkOutput("rst_rdata", dmem_rdata[d], 32'd0);
            checkOutput("rst_ack",   32'(dmem_req_ack[d]), 32'd1);
            checkOutput("rst_ram_en", 32'(ram_en[d]), 32'd0);
            checkOutput("rst_ram_we", 32'(ram_we[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle latency port: lane handling and illegal requests.
        applyStimulus(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h10, 32'hDEADBEEF, w); dropRequest(0);
        applyStimulus(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h10, 32'h0, w);        dropRequest(0);
        applyStimulus(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h13, 32'h000000A5, w); dropRequest(0);
        applyStimulus(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h10, 32'h0, w);
        applyStimulus(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, 32'h0, w);
        applyStimulus(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h11, 32'h0, w);        dropRequest(0);
        applyStimulus(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h20, 32'h55667788, w);
        applyStimulus(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h22, 32'h00001234, w);
        applyStimulus(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h21, 32'h0, w);
        applyStimulus(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h10014, 32'hCAFEF00D, w);
        applyStimulus(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h14, 32'h0, w);
        applyStimulus(0, SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, w);
        applyStimulus(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_ERROR, 32'h10, 32'h0, w);
        applyStimulus(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h12, 32'h0, w);        dropRequest(0);
        drainQueues();

        for (int i = 0; i < 4; i++)
            applyStimulus(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'(4 * i), 32'h0A0B0C00 + 32'(i), w);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'(4 * i), 32'h0, w);
            checkOutput("l1_b2b_wait", 32'(w), 32'd0);
        end
        dropRequest(0);
        drainQueues();

        // Two-cycle latency port: reads stall the next request by one cycle.
        applyStimulus(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h11223344, w);
        applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, w);
        checkOutput("l2_wr_to_rd_wait", 32'(w), 32'd0);
        applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h13, 32'h0, w);
        checkOutput("l2_rd_to_rd_wait", 32'(w), 32'd1);
        applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h11, 32'h0, w);
        checkOutput("l2_rd_to_err_wait", 32'(w), 32'd1);
        dropRequest(1);
        drainQueues();

        // Reset in the middle of a latency-2 read drops its response.
        applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, w);
        dropRequest(1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_resp",  32'(dmem_resp[1]), 32'(SCR1_MEM_RESP_NOTRDY));
        checkOutput("midrst_ack",   32'(dmem_req_ack[1]), 32'd1);
        checkOutput("midrst_rdata", dmem_rdata[1], 32'd0);
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("postrst_ack",    32'(dmem_req_ack[1]), 32'd1);
        checkOutput("postrst_ram_en", 32'(ram_en[1]), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, w);
        dropRequest(1);
        drainQueues();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
